// File: rtl/regread_stage.sv
// regread_stage: integer register file plus operand-read pipeline stage
// sitting between issue and execute.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   wr_en/addr/data      NUM_WPORTS write-back ports (highest index wins)
//   stable_counter       64-bit timer, selectable as a src2 operand
//   flush                drop the held group and the incoming group
//   in_*                 issue group: lane enables, payload, sources, selects
//   in_ready             combinational: !out_valid | out_ready
//   out_*                registered group: lane enables, payload, operands
//
// Build option: define REGREAD_BYPASS_EN for same-cycle write-to-read
// forwarding at capture and refresh of stalled RF operands.
module regread_stage #(
    parameter int NUM_LANES  = 2,
    parameter int NUM_WPORTS = 2,
    parameter int NUM_REGS   = 32,
    parameter int DATA_W     = 32,
    parameter int PAYLOAD_W  = 64,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_WPORTS-1:0]           wr_en,
    input  logic [NUM_WPORTS*ADDR_W-1:0]    wr_addr,
    input  logic [NUM_WPORTS*DATA_W-1:0]    wr_data,
    input  logic [63:0]                     stable_counter,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES-1:0]            in_lane_en,
    input  logic [NUM_LANES*PAYLOAD_W-1:0]  in_payload,
    input  logic [NUM_LANES*ADDR_W-1:0]     in_rj,
    input  logic [NUM_LANES*ADDR_W-1:0]     in_rk,
    input  logic [NUM_LANES*2-1:0]          in_src1_sel,
    input  logic [NUM_LANES*2-1:0]          in_src2_sel,
    input  logic [NUM_LANES*32-1:0]         in_pc,
    input  logic [NUM_LANES*DATA_W-1:0]     in_imm,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES-1:0]            out_lane_en,
    output logic [NUM_LANES*PAYLOAD_W-1:0]  out_payload,
    output logic [NUM_LANES*DATA_W-1:0]     out_op1,
    output logic [NUM_LANES*DATA_W-1:0]     out_op2
);

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic accept;
    logic [NUM_LANES*DATA_W-1:0] cap_op1;
    logic [NUM_LANES*DATA_W-1:0] cap_op2;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Writes commit regardless of stall/flush; later ports override
    // earlier ones through NBA ordering inside the loop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] != '0) begin
                    rf[wr_addr[p*ADDR_W +: ADDR_W]] <=
                        wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef REGREAD_BYPASS_EN
    // Overlay this cycle's writes onto a value; r0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] base
    );
        logic [DATA_W-1:0] v;
        v = base;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (wr_en[p] && a != '0 &&
                wr_addr[p*ADDR_W +: ADDR_W] == a) begin
                v = wr_data[p*DATA_W +: DATA_W];
            end
        end
        return v;
    endfunction
`endif

    function automatic logic [DATA_W-1:0] rf_rd(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = (a == '0) ? '0 : rf[a];
`ifdef REGREAD_BYPASS_EN
        v = fwd(a, v);
`endif
        return v;
    endfunction

    always_comb begin
        cap_op1 = '0;
        cap_op2 = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            unique case (in_src1_sel[l*2 +: 2])
                2'd0: cap_op1[l*DATA_W +: DATA_W] =
                    rf_rd(in_rj[l*ADDR_W +: ADDR_W]);
                2'd1: cap_op1[l*DATA_W +: DATA_W] =
                    DATA_W'(in_pc[l*32 +: 32]);
                default: cap_op1[l*DATA_W +: DATA_W] = '0;
            endcase
            unique case (in_src2_sel[l*2 +: 2])
                2'd0: cap_op2[l*DATA_W +: DATA_W] =
                    rf_rd(in_rk[l*ADDR_W +: ADDR_W]);
                2'd1: cap_op2[l*DATA_W +: DATA_W] =
                    in_imm[l*DATA_W +: DATA_W];
                2'd2: cap_op2[l*DATA_W +: DATA_W] =
                    DATA_W'(stable_counter[31:0]);
                default: cap_op2[l*DATA_W +: DATA_W] =
                    DATA_W'(stable_counter[63:32]);
            endcase
        end
    end

`ifdef REGREAD_BYPASS_EN
    // Source tags of the held group, needed to refresh it while stalled.
    logic [NUM_LANES*ADDR_W-1:0] hold_rj;
    logic [NUM_LANES*ADDR_W-1:0] hold_rk;
    logic [NUM_LANES-1:0]        hold_rf1;
    logic [NUM_LANES-1:0]        hold_rf2;
    logic [NUM_LANES*DATA_W-1:0] ref_op1;
    logic [NUM_LANES*DATA_W-1:0] ref_op2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_rj  <= '0;
            hold_rk  <= '0;
            hold_rf1 <= '0;
            hold_rf2 <= '0;
        end else if (accept) begin
            hold_rj <= in_rj;
            hold_rk <= in_rk;
            for (int l = 0; l < NUM_LANES; l++) begin
                hold_rf1[l] <= in_src1_sel[l*2 +: 2] == 2'd0;
                hold_rf2[l] <= in_src2_sel[l*2 +: 2] == 2'd0;
            end
        end
    end

    always_comb begin
        ref_op1 = out_op1;
        ref_op2 = out_op2;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (hold_rf1[l]) begin
                ref_op1[l*DATA_W +: DATA_W] =
                    fwd(hold_rj[l*ADDR_W +: ADDR_W],
                        out_op1[l*DATA_W +: DATA_W]);
            end
            if (hold_rf2[l]) begin
                ref_op2[l*DATA_W +: DATA_W] =
                    fwd(hold_rk[l*ADDR_W +: ADDR_W],
                        out_op2[l*DATA_W +: DATA_W]);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_lane_en <= '0;
            out_payload <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_lane_en <= in_lane_en;
            out_payload <= in_payload;
            out_op1     <= cap_op1;
            out_op2     <= cap_op2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef REGREAD_BYPASS_EN
        end else if (out_valid) begin
            out_op1 <= ref_op1;
            out_op2 <= ref_op2;
`endif
        end
    end

endmodule

// File: tb/tb_regread_stage.sv
// tb_regread_stage: directed bench for regread_stage with a
// transaction-level model checked every cycle plus literal expectations.
module tb_regread_stage;

    localparam int NL = 2;
    localparam int NW = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int PW = 64;
`ifdef REGREAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [63:0]      stable_counter;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [NL-1:0]    in_lane_en;
    logic [NL*PW-1:0] in_payload;
    logic [NL*AW-1:0] in_rj;
    logic [NL*AW-1:0] in_rk;
    logic [NL*2-1:0]  in_src1_sel;
    logic [NL*2-1:0]  in_src2_sel;
    logic [NL*32-1:0] in_pc;
    logic [NL*DW-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [NL-1:0]    out_lane_en;
    logic [NL*PW-1:0] out_payload;
    logic [NL*DW-1:0] out_op1;
    logic [NL*DW-1:0] out_op2;

    int checks = 0;
    int failures = 0;

    regread_stage dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stable_counter(stable_counter), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_en(in_lane_en), .in_payload(in_payload),
        .in_rj(in_rj), .in_rk(in_rk),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_pc(in_pc), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_en(out_lane_en), .out_payload(out_payload),
        .out_op1(out_op1), .out_op2(out_op2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: architectural RF plus the expected held group.
    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0;
    logic        m_en   [NL];
    logic [63:0] m_pay  [NL];
    logic [31:0] m_op1  [NL];
    logic [31:0] m_op2  [NL];
    logic [4:0]  m_rj   [NL];
    logic [4:0]  m_rk   [NL];
    logic        m_isrf1[NL];
    logic        m_isrf2[NL];

    initial begin
        logic [31:0] pre [32];
        logic [31:0] post[32];
        logic [31:0] rd  [32];
        bit          written[32];
        logic [4:0]  a;
        logic [1:0]  s;
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int r = 0; r < 32; r++) m_rf[r] = '0;
                m_valid = 1'b0;
                for (int l = 0; l < NL; l++) begin
                    m_en[l] = 0; m_pay[l] = 0; m_op1[l] = 0; m_op2[l] = 0;
                    m_rj[l] = 0; m_rk[l] = 0; m_isrf1[l] = 0; m_isrf2[l] = 0;
                end
            end else begin
                pre = m_rf;
                post = m_rf;
                for (int r = 0; r < 32; r++) written[r] = 0;
                for (int p = 0; p < NW; p++) begin
                    a = wr_addr[p*AW +: AW];
                    if (wr_en[p] && a != 0) begin
                        post[a] = wr_data[p*DW +: DW];
                        written[a] = 1;
                    end
                end
                for (int r = 0; r < 32; r++) rd[r] = BYP ? post[r] : pre[r];
                if (flush) begin
                    m_valid = 1'b0;
                end else if (in_valid && (!m_valid || out_ready)) begin
                    m_valid = 1'b1;
                    for (int l = 0; l < NL; l++) begin
                        m_en[l]  = in_lane_en[l];
                        m_pay[l] = in_payload[l*PW +: PW];
                        m_rj[l]  = in_rj[l*AW +: AW];
                        m_rk[l]  = in_rk[l*AW +: AW];
                        s = in_src1_sel[l*2 +: 2];
                        m_isrf1[l] = (s == 0);
                        m_op1[l] = (s == 0) ? rd[m_rj[l]] :
                                   (s == 1) ? in_pc[l*32 +: 32] : 32'h0;
                        s = in_src2_sel[l*2 +: 2];
                        m_isrf2[l] = (s == 0);
                        case (s)
                            2'd0: m_op2[l] = rd[m_rk[l]];
                            2'd1: m_op2[l] = in_imm[l*DW +: DW];
                            2'd2: m_op2[l] = stable_counter[31:0];
                            default: m_op2[l] = stable_counter[63:32];
                        endcase
                    end
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end else if (m_valid && BYP) begin
                    for (int l = 0; l < NL; l++) begin
                        if (m_isrf1[l] && written[m_rj[l]])
                            m_op1[l] = post[m_rj[l]];
                        if (m_isrf2[l] && written[m_rk[l]])
                            m_op2[l] = post[m_rk[l]];
                    end
                end
                m_rf = post;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
                check("out_valid", 64'(out_valid), 64'(m_valid));
                if (m_valid) begin
                    for (int l = 0; l < NL; l++) begin
                        check($sformatf("lane_en[%0d]", l),
                              64'(out_lane_en[l]), 64'(m_en[l]));
                        check($sformatf("payload[%0d]", l),
                              out_payload[l*PW +: PW], m_pay[l]);
                        check($sformatf("op1[%0d]", l),
                              64'(out_op1[l*DW +: DW]), 64'(m_op1[l]));
                        check($sformatf("op2[%0d]", l),
                              64'(out_op2[l*DW +: DW]), 64'(m_op2[l]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        flush = 0; in_valid = 0; in_lane_en = '0; in_payload = '0;
        in_rj = '0; in_rk = '0; in_src1_sel = '0; in_src2_sel = '0;
        in_pc = '0; in_imm = '0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a,
                          input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_lane(input int l, input logic [63:0] pay,
                            input logic [4:0] rj, input logic [4:0] rk,
                            input logic [1:0] s1, input logic [1:0] s2,
                            input logic [31:0] pc, input logic [31:0] imm);
        in_lane_en[l] = 1'b1;
        in_payload[l*PW +: PW] = pay;
        in_rj[l*AW +: AW] = rj;
        in_rk[l*AW +: AW] = rk;
        in_src1_sel[l*2 +: 2] = s1;
        in_src2_sel[l*2 +: 2] = s2;
        in_pc[l*32 +: 32] = pc;
        in_imm[l*DW +: DW] = imm;
    endtask

    initial begin
        clr_in();
        stable_counter = 64'h0000_0007_0000_0009;
        out_ready = 1'b1;
        #12;
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst lane_en", 64'(out_lane_en), 64'h0);
        check("rst payload", out_payload[63:0] | out_payload[127:64], 64'h0);
        check("rst op1", 64'(out_op1), 64'h0);
        check("rst op2", 64'(out_op2), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'h1);
        #1 rstn = 1'b1;
        tick();

        // r0 write ignored; disabled lane1 still carries its payload
        set_wr(0, 5'd0, 32'hDEAD);
        tick();
        clr_in();
        set_lane(0, 64'h100, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0);
        in_payload[PW +: PW] = 64'hABC;
        in_valid = 1;
        tick();
        check("r0 valid", 64'(out_valid), 64'h1);
        check("r0 op1", 64'(out_op1[DW-1:0]), 64'h0);
        check("r0 dis lane", 64'(out_lane_en[1]), 64'h0);

        // same-address write priority and forwarding
        clr_in();
        set_wr(0, 5'd5, 32'h11);
        set_wr(1, 5'd5, 32'h22);
        set_lane(0, 64'h101, 5'd5, 5'd5, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        tick();
        check("fwd op1", 64'(out_op1[DW-1:0]), BYP ? 64'h22 : 64'h0);
        clr_in();
        set_lane(0, 64'h102, 5'd5, 5'd0, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        tick();
        check("prio r5", 64'(out_op1[DW-1:0]), 64'h22);

        // source selects
        clr_in();
        set_lane(1, 64'h103, 5'd5, 5'd5, 2'd1, 2'd3, 32'h1C00_0040, 0);
        set_lane(0, 64'h104, 5'd5, 5'd5, 2'd2, 2'd2, 32'h1234, 0);
        in_valid = 1;
        tick();
        check("pc op1", 64'(out_op1[DW +: DW]), 64'h1C00_0040);
        check("cnth op2", 64'(out_op2[DW +: DW]), 64'h7);
        check("cntl op2", 64'(out_op2[DW-1:0]), 64'h9);
        check("zero op1", 64'(out_op1[DW-1:0]), 64'h0);

        // stall and refresh
        clr_in();
        set_wr(0, 5'd3, 32'hA);
        tick();
        clr_in();
        set_lane(0, 64'h105, 5'd3, 5'd0, 2'd0, 2'd1, 0, 32'h55);
        in_valid = 1;
        out_ready = 0;
        tick();
        check("stall v", 64'(out_valid), 64'h1);
        check("stall op1 c0", 64'(out_op1[DW-1:0]), 64'hA);
        check("stall rdy c0", 64'(in_ready), 64'h0);
        clr_in();
        tick();
        check("stall op1 c1", 64'(out_op1[DW-1:0]), 64'hA);
        set_wr(0, 5'd3, 32'hB);
        tick();
        clr_in();
        check("stall op1 c2", 64'(out_op1[DW-1:0]), BYP ? 64'hB : 64'hA);
        tick();
        check("stall op1 c3", 64'(out_op1[DW-1:0]), BYP ? 64'hB : 64'hA);
        check("stall imm", 64'(out_op2[DW-1:0]), 64'h55);
        check("stall rdy c3", 64'(in_ready), 64'h0);

        // flush while stalled with new input and a write
        set_lane(0, 64'hF00, 5'd3, 5'd0, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        flush = 1;
        set_wr(0, 5'd7, 32'h5);
        tick();
        check("flush v", 64'(out_valid), 64'h0);
        clr_in();
        out_ready = 1;
        tick();
        check("flush drop", 64'(out_valid), 64'h0);
        set_lane(0, 64'h106, 5'd7, 5'd0, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        tick();
        check("flush wr r7", 64'(out_op1[DW-1:0]), 64'h5);

        // reset while stalled loses the group
        clr_in();
        set_lane(0, 64'h107, 5'd3, 5'd0, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        out_ready = 0;
        tick();
        check("rs v", 64'(out_valid), 64'h1);
        clr_in();
        rstn = 0;
        #2;
        check("rs async v", 64'(out_valid), 64'h0);
        check("rs async op1", 64'(out_op1), 64'h0);
        check("rs in_ready", 64'(in_ready), 64'h1);
        #1 rstn = 1;
        tick();
        tick();
        check("rs no out", 64'(out_valid), 64'h0);
        out_ready = 1;
        set_lane(0, 64'h108, 5'd3, 5'd0, 2'd0, 2'd0, 0, 0);
        in_valid = 1;
        tick();
        check("rs rf clr", 64'(out_op1[DW-1:0]), 64'h0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            clr_in();
            set_lane(0, 64'(i), 5'd0, 5'd0, 2'd2, 2'd1, 0, 32'(100 + i));
            in_valid = 1;
            tick();
            check($sformatf("stream v%0d", i), 64'(out_valid), 64'h1);
            check($sformatf("stream op2 %0d", i),
                  64'(out_op2[DW-1:0]), 64'(100 + i));
        end
        clr_in();
        tick();
        check("stream end", 64'(out_valid), 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regread_stage.md
# regread_stage

Parametrised register-file and operand-read pipeline stage between issue and the execute units. Holds the architectural integer register file with `NUM_WPORTS` write-back ports and serves `NUM_LANES` issue lanes, two source operands each. Each lane's sources are selected from the register file, PC, zero, immediate or the stable counter. Operands are registered behind a valid/ready handshake with flush. While the stage is stalled, held operands are refreshed by later write-backs.

## Interface
- `NUM_LANES`, 2, issue lanes.
- `NUM_WPORTS`, 2, write-back ports.
- `NUM_REGS`, 32, architectural registers; `ADDR_W = $clog2(NUM_REGS)`.
- `DATA_W`, 32, register width.
- `PAYLOAD_W`, 64, per-lane opaque pass-through (uop, rd, exception, pc_next, ...).
- Packing: lane/port `i` of any vector occupies `[i*W +: W]`.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_en` in NUM_WPORTS: write-back strobes.
- `wr_addr` in NUM_WPORTS*ADDR_W: write-back addresses.
- `wr_data` in NUM_WPORTS*DATA_W: write-back data.
- `stable_counter` in 64: timer value.
- `flush` in 1: discard the held group and the incoming group.
- `in_valid` in 1: issue group valid.
- `in_ready` out 1: stage can accept.
- `in_lane_en` in NUM_LANES: per-lane valid.
- `in_payload` in NUM_LANES*PAYLOAD_W: per-lane pass-through.
- `in_rj`, `in_rk` in NUM_LANES*ADDR_W: per-lane source register addresses.
- `in_src1_sel`, `in_src2_sel` in NUM_LANES*2: per-lane source selects.
- `in_pc` in NUM_LANES*32: per-lane PC.
- `in_imm` in NUM_LANES*DATA_W: per-lane immediate.
- `out_valid` out 1: output group valid.
- `out_ready` in 1: consumer accepts.
- `out_lane_en` out NUM_LANES: registered lane enables.
- `out_payload` out NUM_LANES*PAYLOAD_W: registered payloads.
- `out_op1`, `out_op2` out NUM_LANES*DATA_W: registered operands.

## Operation
- **Writes** commit every cycle regardless of stall or flush.
  - Writes to r0 are ignored.
  - If several ports write the same address in one cycle, the highest-index port wins.
- **Reads:** register 0 always reads 0.
- **src1 select:** 0 = RF[rj], 1 = pc (zero-extended/truncated to DATA_W), 2 = 0, 3 = 0 (counter ID).
- **src2 select:** 0 = RF[rk], 1 = imm, 2 = `stable_counter[31:0]`, 3 = `stable_counter[63:32]`.
- **Handshake:**
  - `in_ready = !out_valid | out_ready`.
  - Accept when `in_valid & in_ready & !flush`.
  - On accept, capture all lanes; disabled lanes are captured too, but their `out_lane_en` is 0.
- **Drain:** `out_valid & out_ready` with no accept clears `out_valid`.
- **Flush:** clears `out_valid` next cycle and drops the input that cycle; flush has priority over accept and hold.
- **Held-operand refresh:**
  - While `out_valid & !out_ready`, any committed write whose address matches a held RF-selected source (non-zero) replaces that operand next cycle, using the same port priority.
  - PC, imm, zero and counter operands are never refreshed.
- The stage stores per-lane source address and a RF-select flag for refresh.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: one group per cycle when `out_ready` is held high.
- Reset (async, asserted):
  - All register-file entries = 0.
  - `out_valid` = 0, `out_lane_en` = 0.
  - `out_payload`, `out_op1`, `out_op2` = 0.
- `in_ready` is combinational from `out_valid` and `out_ready`; it is 1 during and after reset.
- Same-cycle write and read of the same register: the captured operand equals the write data (see Configuration).
- Reset mid-stall: the held group is lost; no output appears after release until a new accept.
- `flush` with `out_ready` = 0: `out_valid` still clears.

## Configuration
- `REGREAD_BYPASS_EN` defined:
  - Same-cycle write-to-read forwarding is active at capture.
  - Held-operand refresh is active.
- Not defined:
  - Capture reads the pre-write array value.
  - Held operands are frozen.
  - Issue logic must then delay dependants by one cycle after write-back.
- Write and flush behaviour are identical in both builds.

## Test plan
- **Reset and r0:** reset, then write r0 = 0xDEAD; issue lane0 rj = 0 sel RF -> `out_op1[lane0]` = 0. Every output is 0 during reset.
- **Write priority and forwarding:** wr port0 r5 = 0x11 and port1 r5 = 0x22 in the same cycle as an issue reading r5 -> op = 0x22. Without the macro, op = old r5 (0 after reset).
- **Source selects:** lane1 sel1 = PC with pc = 0x1C000040, sel2 = CNTH with counter = 0x0000_0007_0000_0009 -> op1 = 0x1C000040, op2 = 0x7.
- **Stall and refresh:** accept a group reading r3 = 0xA, hold `out_ready` = 0 for 3 cycles, write r3 = 0xB in cycle 2 -> `out_op1` = 0xB from cycle 3, `in_ready` = 0 throughout the stall. An imm operand stays unchanged.
- **Flush:** flush while stalled with `in_valid` = 1 -> `out_valid` = 0 next cycle, the input is not captured, and a concurrent write r7 = 0x5 is still committed.
- **Streaming:** 8 back-to-back groups with `out_ready` = 1 -> 8 consecutive `out_valid` cycles, operands in order.
